// File: rtl/sprite_fetch.sv
// sprite_fetch: sprite ROM address generator and pixel compositor.
// Ports: clka/rsta (async high), frame_start, pix_x/pix_y/pix_de scan,
//   obj_x/obj_y/facing sprite placement, bg_rgb background pixel,
//   rom_addr/rom_data sync ROM (1-cycle read), out_rgb/out_de/out_hit.
// Optional: define SPRITE_MIRROR_EN to honour facing (horizontal mirror).
// Latency from scan inputs to out_* is 3 clocks.
module sprite_fetch #(
    parameter int unsigned SPR_W = 33,
    parameter int unsigned SPR_H = 30,
    parameter logic [15:0] KEY   = 16'h0000
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        frame_start,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_de,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic        facing,
    input  logic [15:0] bg_rgb,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] out_rgb,
    output logic        out_de,
    output logic        out_hit
);

    localparam logic [10:0] W11      = 11'(SPR_W);
    localparam logic [10:0] H11      = 11'(SPR_H);
    localparam logic [9:0]  STEP     = 10'(SPR_W);
    localparam logic [9:0]  BASE_MAX = 10'(SPR_W * (SPR_H - 1));

    logic [9:0]  ox;
    logic [9:0]  oy;
    logic        armed;
    logic [9:0]  base;
    logic        line_hit;
    logic        de_q;
    logic        de_fall;
    logic        x_in;
    logic        y_in;
    logic        win;
    logic [9:0]  col;
    logic [9:0]  eff_col;
    logic [9:0]  addr_nxt;
    logic        win1;
    logic        de1;
    logic [15:0] bg1;
    logic        win2;
    logic        de2;
    logic [15:0] bg2;
    logic        hit_nxt;

    // Window bounds compared in 11 bits so ox+SPR_W never wraps.
    assign x_in = ({1'b0, pix_x} >= {1'b0, ox}) &&
                  ({1'b0, pix_x} <  ({1'b0, ox} + W11));
    assign y_in = ({1'b0, pix_y} >= {1'b0, oy}) &&
                  ({1'b0, pix_y} <  ({1'b0, oy} + H11));
    assign win  = pix_de && x_in && y_in;

    // Column always comes from pix_x, so right-edge clipping is harmless.
    assign col = pix_x - ox;

`ifdef SPRITE_MIRROR_EN
    localparam logic [9:0] WM1 = 10'(SPR_W - 1);
    logic fc;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            fc <= 1'b0;
        end else if (frame_start) begin
            fc <= facing;
        end
    end

    assign eff_col = fc ? (WM1 - col) : col;
`else
    logic unused_facing;
    assign unused_facing = facing;
    assign eff_col       = col;
`endif

    assign addr_nxt = base + eff_col;
    assign de_fall  = de_q && !pix_de;

    // Frame-level placement; armed gates hits until a frame_start is
    // seen so a mid-frame reset cannot composite garbage.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            ox    <= '0;
            oy    <= '0;
            armed <= 1'b0;
        end else if (frame_start) begin
            ox    <= obj_x;
            oy    <= obj_y;
            armed <= 1'b1;
        end
    end

    // Row base advances by SPR_W at the end of every line that touched
    // the sprite rows; it is always a multiple of SPR_W, so the
    // below-max test alone keeps it inside the ROM.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            base     <= '0;
            line_hit <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            de_q <= pix_de;
            if (frame_start) begin
                base     <= '0;
                line_hit <= 1'b0;
            end else if (de_fall) begin
                line_hit <= 1'b0;
                if (line_hit && (base < BASE_MAX)) begin
                    base <= base + STEP;
                end
            end else if (pix_de && y_in) begin
                line_hit <= 1'b1;
            end
        end
    end

    // Stage 1: address out to ROM, flags and background alongside.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rom_addr <= '0;
            win1     <= 1'b0;
            de1      <= 1'b0;
            bg1      <= '0;
        end else begin
            if (win) begin
                rom_addr <= addr_nxt;
            end
            win1 <= win && armed;
            de1  <= pix_de;
            bg1  <= bg_rgb;
        end
    end

    // Stage 2: aligns flags with the ROM word appearing this cycle.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            win2 <= 1'b0;
            de2  <= 1'b0;
            bg2  <= '0;
        end else begin
            win2 <= win1;
            de2  <= de1;
            bg2  <= bg1;
        end
    end

    assign hit_nxt = win2 && (rom_data != KEY);

    // Stage 3: composite.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            out_rgb <= '0;
            out_de  <= 1'b0;
            out_hit <= 1'b0;
        end else begin
            out_rgb <= hit_nxt ? rom_data : bg2;
            out_de  <= de2;
            out_hit <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: self-checking bench for sprite_fetch.
// Scan stimulus against a frame-level model of the sprite rules.
`timescale 1ns/1ps
module tb_sprite_fetch;

    localparam int W = 33;
    localparam int H = 30;
    localparam logic [15:0] KEYV = 16'h0000;
`ifdef SPRITE_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_de = 1'b0;
    logic [9:0]  obj_x = '0;
    logic [9:0]  obj_y = '0;
    logic        facing = 1'b0;
    logic [15:0] bg_rgb = '0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] out_rgb;
    logic        out_de;
    logic        out_hit;

    logic [15:0] rom [0:1023];

    int checks = 0;
    int errors = 0;

    // Model state: frame placement, lines completed in sprite rows.
    int m_ox, m_oy, m_rows, m_addr;
    bit m_fc, m_armed, m_line, m_prev_de;
    logic [15:0] h_rgb [3];
    bit          h_hit [3];
    bit          h_de  [3];

    always #5 clka = ~clka;

    always @(posedge clka) rom_data <= rom[rom_addr];

    sprite_fetch #(.SPR_W(W), .SPR_H(H), .KEY(KEYV)) dut (
        .clka(clka), .rsta(rsta), .frame_start(frame_start),
        .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
        .obj_x(obj_x), .obj_y(obj_y), .facing(facing),
        .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_rgb(out_rgb), .out_de(out_de), .out_hit(out_hit)
    );

    task automatic mreset();
        m_ox = 0; m_oy = 0; m_rows = 0; m_addr = 0;
        m_fc = 0; m_armed = 0; m_line = 0; m_prev_de = 0;
        for (int i = 0; i < 3; i++) begin
            h_rgb[i] = '0; h_hit[i] = 0; h_de[i] = 0;
        end
    endtask

    // Drive one scan sample, predict its results, advance one clock.
    task automatic tick(input bit fs, input int x, input int y,
                        input bit de, input logic [15:0] bg);
        bit yin, win, ehit;
        int c, row;
        logic [15:0] ergb;
        frame_start = fs; pix_x = 10'(x); pix_y = 10'(y);
        pix_de = de; bg_rgb = bg;
        yin = (y >= m_oy) && (y <= m_oy + H - 1);
        win = de && yin && (x >= m_ox) && (x <= m_ox + W - 1);
        ehit = 0; ergb = bg;
        if (win) begin
            c = x - m_ox;
            if (MIR && m_fc) c = W - 1 - c;
            row = (m_rows < H - 1) ? m_rows : H - 1;
            m_addr = row * W + c;
            if (m_armed && rom[m_addr] != KEYV) begin
                ehit = 1; ergb = rom[m_addr];
            end
        end
        h_rgb[2] = h_rgb[1]; h_hit[2] = h_hit[1]; h_de[2] = h_de[1];
        h_rgb[1] = h_rgb[0]; h_hit[1] = h_hit[0]; h_de[1] = h_de[0];
        h_rgb[0] = ergb;     h_hit[0] = ehit;     h_de[0] = de;
        if (fs) begin
            m_ox = obj_x; m_oy = obj_y; m_fc = facing;
            m_rows = 0; m_line = 0; m_armed = 1;
        end else if (m_prev_de && !de) begin
            if (m_line) m_rows++;
            m_line = 0;
        end else if (de && yin) begin
            m_line = 1;
        end
        m_prev_de = de;
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rsta = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        checks++; if (rom_addr !== 10'd0) begin errors++;
            $display("FAIL reset_addr got %0d exp 0", rom_addr); end
        checks++; if (out_rgb !== 16'h0) begin errors++;
            $display("FAIL reset_rgb got %h exp 0000", out_rgb); end
        checks++; if (out_de !== 1'b0) begin errors++;
            $display("FAIL reset_de got %b exp 0", out_de); end
        checks++; if (out_hit !== 1'b0) begin errors++;
            $display("FAIL reset_hit got %b exp 0", out_hit); end
        rsta = 1'b0;
        mreset();
    endtask

    task automatic test_window();
        logic [15:0] b;
        rom[0] = 16'h1234;
        obj_x = 10'd100; obj_y = 10'd50; facing = 1'b0;
        tick(1, 0, 0, 0, 0);
        tick(0, 100, 50, 1, 16'h0f0f);
        checks++; if (rom_addr !== 10'd0) begin errors++;
            $display("FAIL case1_addr got %0d exp 0", rom_addr); end
        tick(0, 101, 50, 1, 16'h0f0f);
        tick(0, 0, 50, 0, 0);
        checks++; if (out_hit !== 1'b1 || out_rgb !== 16'h1234) begin
            errors++;
            $display("FAIL case1_out got %b/%h exp 1/1234", out_hit, out_rgb);
        end
        tick(0, 0, 51, 0, 0);
        tick(0, 100, 51, 1, 0);
        tick(0, 0, 51, 0, 0);
        tick(0, 132, 52, 1, 0);
        checks++; if (rom_addr !== 10'd98) begin errors++;
            $display("FAIL case2_addr got %0d exp 98", rom_addr); end
        tick(0, 0, 52, 0, 0);
        b = 16'($urandom);
        tick(0, 99, 50, 1, b);
        tick(0, 0, 50, 0, 0);
        tick(0, 0, 50, 0, 0);
        checks++;
        if (out_hit !== 1'b0 || out_rgb !== b || out_de !== 1'b1) begin
            errors++;
            $display("FAIL case2_outside got %b/%h/%b exp 0/%h/1",
                     out_hit, out_rgb, out_de, b);
        end
    endtask

    task automatic test_key();
        logic [15:0] b0, b1;
        rom[5] = 16'h0000;
        rom[6] = 16'hF800;
        obj_x = 10'd200; obj_y = 10'd100;
        tick(1, 0, 0, 0, 0);
        b0 = 16'($urandom); b1 = 16'($urandom);
        tick(0, 205, 100, 1, b0);
        tick(0, 206, 100, 1, b1);
        tick(0, 0, 100, 0, 0);
        checks++; if (out_hit !== 1'b0 || out_rgb !== b0) begin errors++;
            $display("FAIL key_transp got %b/%h exp 0/%h", out_hit, out_rgb, b0);
        end
        tick(0, 0, 100, 0, 0);
        checks++; if (out_hit !== 1'b1 || out_rgb !== 16'hF800) begin
            errors++;
            $display("FAIL key_opaque got %b/%h exp 1/f800", out_hit, out_rgb);
        end
    endtask

    task automatic test_mirror();
        int e;
        obj_x = 10'd100; obj_y = 10'd50; facing = 1'b1;
        tick(1, 0, 0, 0, 0);
        tick(0, 100, 50, 1, 0);
        e = MIR ? 32 : 0;
        checks++; if (rom_addr !== 10'(e)) begin errors++;
            $display("FAIL mirror_c0 got %0d exp %0d", rom_addr, e); end
        tick(0, 110, 50, 1, 0);
        e = MIR ? 22 : 10;
        checks++; if (rom_addr !== 10'(e)) begin errors++;
            $display("FAIL mirror_c10 got %0d exp %0d", rom_addr, e); end
        tick(0, 0, 50, 0, 0);
        tick(0, 0, 50, 0, 0);
        facing = 1'b0;
    endtask

    task automatic test_midframe();
        obj_x = 10'd620; obj_y = 10'd0; facing = 1'b0;
        tick(1, 0, 0, 0, 0);
        for (int y = 0; y < 6; y++) begin
            if (y == 2) obj_x = 10'd300;
            for (int x = 610; x < 640; x++) begin
                tick(0, x, y, 1, 16'($urandom));
                checks++; if (rom_addr !== 10'(m_addr)) begin errors++;
                    $display("FAIL mid_addr y=%0d x=%0d got %0d exp %0d",
                             y, x, rom_addr, m_addr); end
                checks++;
                if ({out_de, out_hit, out_rgb} !== {h_de[2], h_hit[2], h_rgb[2]})
                begin errors++;
                    $display("FAIL mid_out got %b/%b/%h exp %b/%b/%h", out_de,
                             out_hit, out_rgb, h_de[2], h_hit[2], h_rgb[2]);
                end
            end
            checks++; if (rom_addr !== 10'(y * 33 + 19)) begin errors++;
                $display("FAIL clip_col19 y=%0d got %0d exp %0d",
                         y, rom_addr, y * 33 + 19); end
            repeat (3) tick(0, 0, y, 0, 0);
        end
        tick(1, 0, 0, 0, 0);
        tick(0, 300, 0, 1, 0);
        checks++; if (rom_addr !== 10'd0) begin errors++;
            $display("FAIL mid_newframe got %0d exp 0", rom_addr); end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        int e;
        obj_x = 10'd40; obj_y = 10'd10;
        tick(1, 0, 0, 0, 0);
        for (int n = 0; n < 34; n++) begin
            tick(0, 40, 11, 1, 0);
            e = ((n < H - 1) ? n : H - 1) * W;
            checks++; if (rom_addr !== 10'(e)) begin errors++;
                $display("FAIL sat_base n=%0d got %0d exp %0d", n, rom_addr, e);
            end
            tick(0, 0, 11, 0, 0);
        end
        tick(0, 41, 10, 1, 0);
        // frame_start on the same cycle as a pix_de falling edge
        tick(1, 0, 10, 0, 0);
        tick(0, 40, 10, 1, 0);
        checks++; if (rom_addr !== 10'd0) begin errors++;
            $display("FAIL fs_vs_fall got %0d exp 0", rom_addr); end
        tick(0, 0, 10, 0, 0);
    endtask

    task automatic test_reset_mid();
        obj_x = 10'd10; obj_y = 10'd55;
        tick(1, 0, 0, 0, 0);
        for (int y = 55; y < 60; y++) begin
            for (int x = 8; x < 20; x++) tick(0, x, y, 1, 16'($urandom));
            tick(0, 0, y, 0, 0);
        end
        for (int x = 8; x < 15; x++) tick(0, x, 60, 1, 16'($urandom));
        #2;
        rsta = 1'b1;
        #1;
        checks++;
        if ({rom_addr, out_rgb, out_de, out_hit} !== 28'h0) begin errors++;
            $display("FAIL rst_mid got %0d/%h/%b/%b exp 0/0000/0/0",
                     rom_addr, out_rgb, out_de, out_hit);
        end
        @(posedge clka);
        #1;
        rsta = 1'b0;
        obj_x = 10'd0; obj_y = 10'd0;
        mreset();
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 40; x++) begin
                tick(0, x, y, 1, 16'($urandom));
                checks++;
                if (out_hit !== 1'b0 || out_rgb !== h_rgb[2]) begin errors++;
                    $display("FAIL rst_nohit got %b/%h exp 0/%h",
                             out_hit, out_rgb, h_rgb[2]);
                end
            end
            tick(0, 0, y, 0, 0);
        end
        tick(1, 0, 0, 0, 0);
        for (int x = 0; x < 40; x++) begin
            tick(0, x, 0, 1, 16'($urandom));
            checks++;
            if ({out_de, out_hit, out_rgb} !== {h_de[2], h_hit[2], h_rgb[2]})
            begin errors++;
                $display("FAIL rst_rearm got %b/%b/%h exp %b/%b/%h", out_de,
                         out_hit, out_rgb, h_de[2], h_hit[2], h_rgb[2]);
            end
        end
        repeat (3) tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int ox, oy, x0, x1, y0, y1;
        bit de;
        for (int f = 0; f < 5; f++) begin
            ox = $urandom_range(0, 1000);
            oy = (f == 4) ? 1005 : $urandom_range(0, 1000);
            obj_x = 10'(ox); obj_y = 10'(oy);
            facing = 1'($urandom_range(0, 1));
            tick(1, 0, 0, 0, 0);
            obj_x = 10'($urandom); obj_y = 10'($urandom);
            facing = ~facing;
            y0 = (oy > 2) ? oy - 2 : 0;
            y1 = (oy + H + 1 < 1023) ? oy + H + 1 : 1023;
            x0 = (ox > 3) ? ox - 3 : 0;
            x1 = (ox + W + 2 < 1023) ? ox + W + 2 : 1023;
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1 + 2; x++) begin
                    de = (x <= x1) && ($urandom_range(0, 15) != 0);
                    tick(0, x, y, de, 16'($urandom));
                    checks++; if (rom_addr !== 10'(m_addr)) begin errors++;
                        $display("FAIL rnd_addr y=%0d x=%0d got %0d exp %0d",
                                 y, x, rom_addr, m_addr); end
                    checks++;
                    if ({out_de, out_hit, out_rgb} !==
                        {h_de[2], h_hit[2], h_rgb[2]}) begin errors++;
                        $display("FAIL rnd_out got %b/%b/%h exp %b/%b/%h",
                                 out_de, out_hit, out_rgb,
                                 h_de[2], h_hit[2], h_rgb[2]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = ($urandom_range(0, 7) == 0) ? KEYV : (16'($urandom) | 16'h1);
        end
        mreset();
        test_reset();
        test_window();
        test_key();
        test_mirror();
        test_midframe();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
